// File: rtl/conv2_channel_scheduler.sv
// conv2 branch sequencer: walks every (filter, channel) pair, selects the
// weight/result banks, and holds run until the datapath branch reports done.
module conv2_channel_scheduler #(
  parameter int ADDR_WIDTH     = 16,
  parameter int CHANNEL_NUM    = 2,
  parameter int FILTER_NUM     = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  dp_done,
  output logic                  run,
  output logic [ADDR_WIDTH-1:0] channel_count,
  output logic [ADDR_WIDTH-1:0] filter_count,
  output logic [2:0]            M10K_read_select,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SET_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] CH_LAST = ADDR_WIDTH'(CHANNEL_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] FI_LAST = ADDR_WIDTH'(FILTER_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN,
    FINISH
  } state_t;

  state_t state, state_d;

  logic [SW-1:0]         set_cnt, set_d;
  logic [TW-1:0]         to_cnt, to_d;
  logic [ADDR_WIDTH-1:0] ch_d, fi_d;
  logic                  err_d;

  always_comb begin
    state_d = state;
    set_d   = set_cnt;
    to_d    = to_cnt;
    ch_d    = channel_count;
    fi_d    = filter_count;
    err_d   = error;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = SETUP;
          set_d   = '0;
          ch_d    = '0;
          fi_d    = '0;
          err_d   = 1'b0;
        end
      end
      SETUP: begin
        if (set_cnt == SET_LAST) begin
          state_d = RUN;
          set_d   = '0;
          to_d    = '0;
        end else begin
          set_d = set_cnt + SW'(1);
        end
      end
      RUN: begin
        if (dp_done) begin
          state_d = DRAIN;
        end else if (to_cnt == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          ch_d    = '0;
          fi_d    = '0;
          to_d    = '0;
        end else begin
          to_d = to_cnt + TW'(1);
        end
      end
      DRAIN: begin
        set_d = '0;
        if (channel_count < CH_LAST) begin
          ch_d    = channel_count + ADDR_WIDTH'(1);
          state_d = SETUP;
        end else if (filter_count == FI_LAST) begin
          state_d = FINISH;
        end else begin
          ch_d    = '0;
          fi_d    = filter_count + ADDR_WIDTH'(1);
          state_d = SETUP;
        end
      end
      FINISH: begin
        state_d = IDLE;
        ch_d    = '0;
        fi_d    = '0;
      end
      default: begin
        state_d = IDLE;
        ch_d    = '0;
        fi_d    = '0;
      end
    endcase

    // abort wins over everything but leaves the timeout flag alone
    if (abort && state != IDLE) begin
      state_d = IDLE;
      set_d   = '0;
      to_d    = '0;
      ch_d    = '0;
      fi_d    = '0;
      err_d   = error;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      set_cnt       <= '0;
      to_cnt        <= '0;
      channel_count <= '0;
      filter_count  <= '0;
      error         <= 1'b0;
      run           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      set_cnt       <= set_d;
      to_cnt        <= to_d;
      channel_count <= ch_d;
      filter_count  <= fi_d;
      error         <= err_d;
      run           <= (state_d == RUN);
      busy          <= (state_d != IDLE);
      done          <= (state_d == FINISH);
    end
  end

  assign M10K_read_select = filter_count[2:0];

endmodule

// File: tb/tb_conv2_channel_scheduler.sv
// Bench for conv2_channel_scheduler: cycle-accurate pass traces,
// abort, timeout, async reset and single-pair configuration.
module tb_conv2_channel_scheduler;

  typedef struct packed {
    logic        run;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] ch;
    logic [15:0] fi;
  } chk_t;

  typedef struct {
    int   cyc;
    logic st;
    logic sp;
    chk_t e;
  } vec_t;

  localparam int NV = 19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic spur = 1'b0;
  logic dp_en = 1'b1;

  logic        run_a, busy_a, done_a, err_a, dp_a;
  logic [15:0] ch_a, fi_a;
  logic [2:0]  rs_a;
  logic        run_b, busy_b, done_b, err_b, dp_b;
  logic [15:0] ch_b, fi_b;
  logic [2:0]  rs_b;

  int rc_a = 0;
  int rc_b = 0;
  int sel = 0;
  int checks = 0;
  int failures = 0;

  chk_t sb[$];
  vec_t vt[NV];

  always #5 clk = ~clk;

  // datapath model: done on the 5th run cycle, held until run drops
  always @(posedge clk) rc_a <= run_a ? rc_a + 1 : 0;
  always @(posedge clk) rc_b <= run_b ? rc_b + 1 : 0;
  assign dp_a = (dp_en && run_a && rc_a >= 4) || spur;
  assign dp_b = (dp_en && run_b && rc_b >= 4) || spur;

  conv2_channel_scheduler #(
    .ADDR_WIDTH(16), .CHANNEL_NUM(2), .FILTER_NUM(3),
    .SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dp_done(dp_a), .run(run_a), .channel_count(ch_a),
    .filter_count(fi_a), .M10K_read_select(rs_a),
    .busy(busy_a), .done(done_a), .error(err_a)
  );

  conv2_channel_scheduler #(
    .ADDR_WIDTH(16), .CHANNEL_NUM(1), .FILTER_NUM(1),
    .SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dp_done(dp_b), .run(run_b), .channel_count(ch_b),
    .filter_count(fi_b), .M10K_read_select(rs_b),
    .busy(busy_b), .done(done_b), .error(err_b)
  );

  function automatic chk_t mk(logic r, logic b, logic d, logic er,
                              int ch, int fi);
    chk_t e;
    e.run  = r;
    e.busy = b;
    e.done = d;
    e.err  = er;
    e.ch   = 16'(ch);
    e.fi   = 16'(fi);
    return e;
  endfunction

  // expected trace of a clean pass started in cycle 0
  function automatic chk_t exp_pass(int c, int nch, int nf);
    chk_t e;
    int np;
    int k;
    int p;
    e  = '0;
    np = nch * nf;
    if (c >= 1 && c <= 8 * np) begin
      k      = (c - 1) / 8;
      p      = (c - 1) % 8;
      e.busy = 1'b1;
      e.run  = (p >= 2 && p <= 6);
      e.ch   = 16'(k % nch);
      e.fi   = 16'(k / nch);
    end else if (c == 8 * np + 1) begin
      e.busy = 1'b1;
      e.done = 1'b1;
      e.ch   = 16'(nch - 1);
      e.fi   = 16'(nf - 1);
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input int c);
    chk_t e;
    chk_t a;
    logic [2:0] rs;
    logic [2:0] ers;
    e = sb.pop_front();
    if (sel == 0) begin
      a  = {run_a, busy_a, done_a, err_a, ch_a, fi_a};
      rs = rs_a;
    end else begin
      a  = {run_b, busy_b, done_b, err_b, ch_b, fi_b};
      rs = rs_b;
    end
    ers = e.fi[2:0];
    checks++;
    if (a !== e || rs !== ers) begin
      failures++;
      $display("FAIL %s cyc=%0d got run=%b busy=%b done=%b err=%b ch=%0d fi=%0d rs=%0d expected run=%b busy=%b done=%b err=%b ch=%0d fi=%0d rs=%0d",
               nm, c, a.run, a.busy, a.done, a.err, a.ch, a.fi, rs,
               e.run, e.busy, e.done, e.err, e.ch, e.fi, ers);
    end
  endtask

  task automatic do_pass(input int mode);
    for (int c = 0; c <= 52; c++) begin
      chk_t e;
      int hit;
      hit = -1;
      @(posedge clk); #1;
      e     = exp_pass(c, 2, 3);
      start = (c == 0);
      spur  = 1'b0;
      for (int i = 0; i < NV; i++)
        if (vt[i].cyc == c) hit = i;
      if (hit >= 0) begin
        e = vt[hit].e;
        if (mode == 1) begin
          start = vt[hit].st;
          spur  = vt[hit].sp;
        end
      end
      sb.push_back(e);
      @(negedge clk);
      cmp(mode == 1 ? "pass_disturbed" : "pass_clean", c);
    end
    start = 1'b0;
    spur  = 1'b0;
  endtask

  initial begin
    vt[0]  = '{0,  1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    vt[1]  = '{1,  1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0)};
    vt[2]  = '{2,  1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0)};
    vt[3]  = '{3,  1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0)};
    vt[4]  = '{5,  1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0)};
    vt[5]  = '{7,  1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0)};
    vt[6]  = '{8,  1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0)};
    vt[7]  = '{9,  1'b0, 1'b1, mk(0, 1, 0, 0, 1, 0)};
    vt[8]  = '{10, 1'b0, 1'b1, mk(0, 1, 0, 0, 1, 0)};
    vt[9]  = '{11, 1'b0, 1'b0, mk(1, 1, 0, 0, 1, 0)};
    vt[10] = '{19, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 1)};
    vt[11] = '{27, 1'b0, 1'b0, mk(1, 1, 0, 0, 1, 1)};
    vt[12] = '{30, 1'b1, 1'b0, mk(1, 1, 0, 0, 1, 1)};
    vt[13] = '{35, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 2)};
    vt[14] = '{43, 1'b0, 1'b0, mk(1, 1, 0, 0, 1, 2)};
    vt[15] = '{47, 1'b0, 1'b0, mk(1, 1, 0, 0, 1, 2)};
    vt[16] = '{48, 1'b0, 1'b0, mk(0, 1, 0, 0, 1, 2)};
    vt[17] = '{49, 1'b0, 1'b0, mk(0, 1, 1, 0, 1, 2)};
    vt[18] = '{50, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};

    // reset state of both configurations
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 0; sb.push_back('0); cmp("reset_a", 0);
    sel = 1; sb.push_back('0); cmp("reset_b", 0);
    reset = 1'b0;
    sel = 0;

    // start together with abort in IDLE: stay idle
    for (int c = 0; c <= 2; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      abort = (c == 0);
      sb.push_back('0);
      @(negedge clk);
      cmp("start_abort_idle", c);
    end
    abort = 1'b0;
    start = 1'b0;

    do_pass(0);
    do_pass(1);

    // abort mid-RUN of pair (0,1), then a fresh pass
    for (int c = 0; c <= 80; c++) begin
      chk_t e;
      @(posedge clk); #1;
      start = (c == 0 || c == 25);
      abort = (c == 20);
      if (c <= 20)      e = exp_pass(c, 2, 3);
      else if (c <= 25) e = '0;
      else              e = exp_pass(c - 25, 2, 3);
      sb.push_back(e);
      @(negedge clk);
      cmp("abort", c);
    end
    start = 1'b0;
    abort = 1'b0;

    // datapath never finishes: timeout after 16 run cycles
    dp_en = 1'b0;
    for (int c = 0; c <= 27; c++) begin
      chk_t e;
      @(posedge clk); #1;
      start = (c == 0 || c == 22);
      abort = (c == 26);
      e = '0;
      if (c >= 1 && c <= 18)      e = mk(c >= 3, 1, 0, 0, 0, 0);
      else if (c >= 19 && c <= 22) e = mk(0, 0, 0, 1, 0, 0);
      else if (c >= 23 && c <= 26) e = mk(c >= 25, 1, 0, 0, 0, 0);
      sb.push_back(e);
      @(negedge clk);
      cmp("timeout", c);
    end
    start = 1'b0;
    abort = 1'b0;
    dp_en = 1'b1;

    // asynchronous reset during RUN of pair (1,0)
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      sb.push_back(exp_pass(c, 2, 3));
      @(negedge clk);
      cmp("pre_reset", c);
    end
    start = 1'b0;
    #1 reset = 1'b1;
    #1 sb.push_back('0);
    cmp("async_reset", 12);
    @(posedge clk); #1;
    reset = 1'b0;

    // single-pair configuration
    sel = 1;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      sb.push_back(exp_pass(c, 1, 1));
      @(negedge clk);
      cmp("single_pair", c);
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
